// File: rtl/vector_motor_ctrl.sv
// Differential-drive motor controller: mixes BLE (direction, magnitude)
// vectors into slew-limited left/right duties and 8-bit PWM, with watchdog.
module vector_motor_ctrl #(
    parameter int PWM_DIV        = 4,
    parameter int RAMP_DIV       = 100_000,
    parameter int RAMP_STEP      = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] direction,
    input  logic [7:0] magnitude,
    input  logic       vector_valid,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic [7:0] duty_left,
    output logic [7:0] duty_right,
    output logic       timed_out,
    output logic       active
);

    localparam int PD_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int RD_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PD_W-1:0] PD_MAX = PD_W'(PWM_DIV - 1);
    localparam logic [RD_W-1:0] RD_MAX = RD_W'(RAMP_DIV - 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]      STEP9  = 9'(RAMP_STEP);

    typedef enum logic {
        STOPPED,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0]      tgt_l_q, tgt_l_d;
    logic [7:0]      tgt_r_q, tgt_r_d;
    logic [7:0]      duty_l_q, duty_l_d;
    logic [7:0]      duty_r_q, duty_r_d;
    logic [RD_W-1:0] rdiv_q, rdiv_d;
    logic [PD_W-1:0] pdiv_q, pdiv_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [7:0]      app_l_q, app_l_d;
    logic [7:0]      app_r_q, app_r_d;
    logic            timed_out_q, timed_out_d;
    logic            active_q, active_d;

    logic [9:0] sum_l, sum_r;
    logic [7:0] mix_l, mix_r;
    logic       ramp_tick;
    logic       pwm_step;
    logic       pwm_wrap;

    // Clamp a 10-bit two's complement sum into 0..255.
    function automatic logic [7:0] sat8(input logic [9:0] v);
        logic [7:0] r;
        if (v[9])
            r = 8'd0;
        else if (v[8])
            r = 8'd255;
        else
            r = v[7:0];
        return r;
    endfunction

    // One slew step of duty toward target, never overshooting or wrapping.
    function automatic logic [7:0] ramp(input logic [7:0] duty,
                                        input logic [7:0] tgt);
        logic [8:0] up;
        logic [8:0] dn;
        logic [7:0] r;
        up = {1'b0, duty} + STEP9;
        dn = {1'b0, duty} - STEP9;
        r  = duty;
        if (duty < tgt)
            r = (up >= {1'b0, tgt}) ? tgt : up[7:0];
        else if (duty > tgt)
            r = (dn[8] || (dn[7:0] <= tgt)) ? tgt : dn[7:0];
        return r;
    endfunction

    // Differential mix of the incoming vector.
    always_comb begin
        sum_l = {2'b00, magnitude} + {{2{direction[7]}}, direction};
        sum_r = {2'b00, magnitude} - {{2{direction[7]}}, direction};
        mix_l = sat8(sum_l);
        mix_r = sat8(sum_r);
    end

    // Watchdog FSM; a vector in the expiry cycle takes priority.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        tgt_l_d = tgt_l_q;
        tgt_r_d = tgt_r_q;
        if (vector_valid) begin
            state_d = RUN;
            wd_d    = '0;
            tgt_l_d = mix_l;
            tgt_r_d = mix_r;
        end else if (wd_q == WD_MAX) begin
            state_d = STOPPED;
            tgt_l_d = 8'd0;
            tgt_r_d = 8'd0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        timed_out_d = (state_d == STOPPED);
    end

    // Ramp prescaler and slew-limited duty; enable low zeroes duty at once.
    always_comb begin
        ramp_tick = (rdiv_q == RD_MAX);
        rdiv_d    = ramp_tick ? '0 : rdiv_q + 1'b1;
        duty_l_d  = duty_l_q;
        duty_r_d  = duty_r_q;
        if (!enable) begin
            duty_l_d = 8'd0;
            duty_r_d = 8'd0;
        end else if (ramp_tick) begin
            duty_l_d = ramp(duty_l_q, tgt_l_q);
            duty_r_d = ramp(duty_r_q, tgt_r_q);
        end
        active_d = (duty_l_q != 8'd0) || (duty_r_q != 8'd0);
    end

    // PWM counter; duty is sampled only at wrap so periods stay glitch-free.
    always_comb begin
        pwm_step  = (pdiv_q == PD_MAX);
        pdiv_d    = pwm_step ? '0 : pdiv_q + 1'b1;
        pwm_cnt_d = pwm_step ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        pwm_wrap  = pwm_step && (pwm_cnt_q == 8'hFF);
        app_l_d   = app_l_q;
        app_r_d   = app_r_q;
        if (pwm_wrap) begin
            app_l_d = enable ? duty_l_q : 8'd0;
            app_r_d = enable ? duty_r_q : 8'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STOPPED;
            wd_q        <= '0;
            tgt_l_q     <= 8'd0;
            tgt_r_q     <= 8'd0;
            duty_l_q    <= 8'd0;
            duty_r_q    <= 8'd0;
            rdiv_q      <= '0;
            pdiv_q      <= '0;
            pwm_cnt_q   <= 8'd0;
            app_l_q     <= 8'd0;
            app_r_q     <= 8'd0;
            timed_out_q <= 1'b1;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            tgt_l_q     <= tgt_l_d;
            tgt_r_q     <= tgt_r_d;
            duty_l_q    <= duty_l_d;
            duty_r_q    <= duty_r_d;
            rdiv_q      <= rdiv_d;
            pdiv_q      <= pdiv_d;
            pwm_cnt_q   <= pwm_cnt_d;
            app_l_q     <= app_l_d;
            app_r_q     <= app_r_d;
            timed_out_q <= timed_out_d;
            active_q    <= active_d;
        end
    end

    assign pwm_left   = enable && (pwm_cnt_q < app_l_q);
    assign pwm_right  = enable && (pwm_cnt_q < app_r_q);
    assign duty_left  = duty_l_q;
    assign duty_right = duty_r_q;
    assign timed_out  = timed_out_q;
    assign active     = active_q;

endmodule

// File: tb/tb_vector_motor_ctrl.sv
// Directed bench for vector_motor_ctrl with shortened timing parameters.
// Expected values are hand-computed from the mixing/ramp/watchdog rules.
module tb_vector_motor_ctrl;

    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] direction;
    logic [7:0] magnitude;
    logic       vector_valid;
    logic       pwm_left;
    logic       pwm_right;
    logic [7:0] duty_left;
    logic [7:0] duty_right;
    logic       timed_out;
    logic       active;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] seq_l[$];
    logic [7:0] seq_r[$];
    logic [7:0] l_at_r[$];

    vector_motor_ctrl #(
        .PWM_DIV       (1),
        .RAMP_DIV      (4),
        .RAMP_STEP     (16),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .direction   (direction),
        .magnitude   (magnitude),
        .vector_valid(vector_valid),
        .pwm_left    (pwm_left),
        .pwm_right   (pwm_right),
        .duty_left   (duty_left),
        .duty_right  (duty_right),
        .timed_out   (timed_out),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic pulse(input logic [7:0] d, input logic [7:0] m);
        direction    = d;
        magnitude    = m;
        vector_valid = 1'b1;
        @(posedge clk);
        #1;
        vector_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        logic [7:0] pl;
        logic [7:0] pr;
        seq_l.delete();
        seq_r.delete();
        l_at_r.delete();
        pl = duty_left;
        pr = duty_right;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (duty_left !== pl) begin
                seq_l.push_back(duty_left);
                pl = duty_left;
            end
            if (duty_right !== pr) begin
                seq_r.push_back(duty_right);
                l_at_r.push_back(duty_left);
                pr = duty_right;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        enable       = 1'b1;
        vector_valid = 1'b0;
        direction    = 8'd0;
        magnitude    = 8'd0;
        #23;
        n_cmp++;
        if (duty_left !== 8'd0 || duty_right !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_duty: got %0d/%0d expected 0/0",
                     duty_left, duty_right);
        end
        n_cmp++;
        if (timed_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_timed_out: got %b expected 1", timed_out);
        end
        n_cmp++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active: got %b expected 0", active);
        end
        n_cmp++;
        if (pwm_left !== 1'b0 || pwm_right !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pwm: got %b%b expected 00",
                     pwm_left, pwm_right);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (pwm_left !== 1'b0 || pwm_right !== 1'b0 ||
                duty_left !== 8'd0 || duty_right !== 8'd0 ||
                timed_out !== 1'b1)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_mix_64();
        logic [7:0] exp_s [4];
        int hl;
        int hr;
        exp_s = '{8'd16, 8'd32, 8'd48, 8'd64};
        pulse(8'd0, 8'd64);
        n_cmp++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL run_timed_out: got %b expected 0", timed_out);
        end
        capture(40);
        n_cmp++;
        if (seq_l.size() != 4 || seq_r.size() != 4) begin
            n_fail++;
            $display("FAIL ramp64_steps: got %0d/%0d expected 4/4",
                     seq_l.size(), seq_r.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (seq_l[i] !== exp_s[i] || seq_r[i] !== exp_s[i]) begin
                    n_fail++;
                    $display("FAIL ramp64_seq: got %0d/%0d expected %0d",
                             seq_l[i], seq_r[i], exp_s[i]);
                end
            end
        end
        n_cmp++;
        if (active !== 1'b1) begin
            n_fail++;
            $display("FAIL active_on: got %b expected 1", active);
        end
        repeat (260) @(posedge clk);
        #1;
        hl = 0;
        hr = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_left)
                hl++;
            if (pwm_right)
                hr++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (hl != 64 || hr != 64) begin
            n_fail++;
            $display("FAIL pwm64_high: got %0d/%0d expected 64/64", hl, hr);
        end
    endtask

    task automatic test_sat_high();
        int bad;
        pulse(8'd100, 8'd200);
        capture(80);
        n_cmp++;
        if (seq_l.size() != 12) begin
            n_fail++;
            $display("FAIL sat_l_steps: got %0d expected 12", seq_l.size());
        end else begin
            n_cmp++;
            if (seq_l[10] !== 8'd240 || seq_l[11] !== 8'd255) begin
                n_fail++;
                $display("FAIL sat_l_tail: got %0d,%0d expected 240,255",
                         seq_l[10], seq_l[11]);
            end
        end
        bad = 0;
        for (int i = 1; i < seq_l.size(); i++)
            if (seq_l[i] <= seq_l[i-1])
                bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sat_l_monotonic: got %0d drops expected 0", bad);
        end
        n_cmp++;
        if (seq_r.size() != 3) begin
            n_fail++;
            $display("FAIL sat_r_steps: got %0d expected 3", seq_r.size());
        end else if (seq_r[0] !== 8'd80 || seq_r[1] !== 8'd96 ||
                     seq_r[2] !== 8'd100) begin
            n_fail++;
            $display("FAIL sat_r_seq: got %0d,%0d,%0d expected 80,96,100",
                     seq_r[0], seq_r[1], seq_r[2]);
        end
        n_cmp++;
        if (duty_left !== 8'd255 || duty_right !== 8'd100) begin
            n_fail++;
            $display("FAIL sat_final: got %0d/%0d expected 255/100",
                     duty_left, duty_right);
        end
    endtask

    task automatic test_cross();
        logic [7:0] exp_r [5];
        exp_r = '{8'd116, 8'd132, 8'd148, 8'd164, 8'd178};
        pulse(8'h80, 8'd50);
        capture(100);
        n_cmp++;
        if (seq_l.size() != 16) begin
            n_fail++;
            $display("FAIL cross_l_steps: got %0d expected 16", seq_l.size());
        end else if (seq_l[14] !== 8'd15 || seq_l[15] !== 8'd0) begin
            n_fail++;
            $display("FAIL cross_l_tail: got %0d,%0d expected 15,0",
                     seq_l[14], seq_l[15]);
        end
        n_cmp++;
        if (seq_r.size() != 5) begin
            n_fail++;
            $display("FAIL cross_r_steps: got %0d expected 5", seq_r.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (seq_r[i] !== exp_r[i]) begin
                    n_fail++;
                    $display("FAIL cross_r_seq: got %0d expected %0d",
                             seq_r[i], exp_r[i]);
                end
            end
            n_cmp++;
            if (l_at_r[4] !== 8'd175) begin
                n_fail++;
                $display("FAIL cross_concurrent: got %0d expected 175",
                         l_at_r[4]);
            end
        end
        n_cmp++;
        if (duty_left !== 8'd0 || duty_right !== 8'd178) begin
            n_fail++;
            $display("FAIL cross_final: got %0d/%0d expected 0/178",
                     duty_left, duty_right);
        end
    endtask

    task automatic test_timeout();
        pulse(8'd0, 8'd64);
        repeat (T - 1) @(posedge clk);
        #1;
        n_cmp++;
        if (timed_out !== 1'b0 || duty_left !== 8'd64 ||
            duty_right !== 8'd64) begin
            n_fail++;
            $display("FAIL pre_expiry: got to=%b %0d/%0d expected 0 64/64",
                     timed_out, duty_left, duty_right);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (timed_out !== 1'b1) begin
            n_fail++;
            $display("FAIL expiry: got %b expected 1", timed_out);
        end
        capture(40);
        n_cmp++;
        if (seq_l.size() != 4) begin
            n_fail++;
            $display("FAIL decel_steps: got %0d expected 4", seq_l.size());
        end else if (seq_l[0] !== 8'd48 || seq_l[1] !== 8'd32 ||
                     seq_l[2] !== 8'd16 || seq_l[3] !== 8'd0) begin
            n_fail++;
            $display("FAIL decel_seq: got %0d,%0d,%0d,%0d expected 48,32,16,0",
                     seq_l[0], seq_l[1], seq_l[2], seq_l[3]);
        end
        n_cmp++;
        if (active !== 1'b0 || duty_right !== 8'd0) begin
            n_fail++;
            $display("FAIL decel_idle: got act=%b r=%0d expected 0 0",
                     active, duty_right);
        end
        pulse(8'd0, 8'd64);
        n_cmp++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: got %b expected 0", timed_out);
        end
        repeat (T - 1) @(posedge clk);
        #1;
        pulse(8'd0, 8'd64);
        n_cmp++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_race: got %b expected 0", timed_out);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_race_hold: got %b expected 0", timed_out);
        end
    endtask

    task automatic test_enable();
        logic found;
        int   bad;
        pulse(8'd0, 8'd128);
        repeat (300) @(posedge clk);
        #1;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pwm_left) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL en_pwm_seen: got %b expected 1", found);
        end
        enable = 1'b0;
        #1;
        n_cmp++;
        if (pwm_left !== 1'b0 || pwm_right !== 1'b0) begin
            n_fail++;
            $display("FAIL en_gate: got %b%b expected 00",
                     pwm_left, pwm_right);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (duty_left !== 8'd0 || duty_right !== 8'd0) begin
            n_fail++;
            $display("FAIL en_duty_zero: got %0d/%0d expected 0/0",
                     duty_left, duty_right);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (pwm_left || pwm_right || duty_left != 0 || duty_right != 0)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_low_hold: got %0d bad cycles expected 0", bad);
        end
        n_cmp++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_state: got %b expected 0", timed_out);
        end
        enable = 1'b1;
        capture(60);
        n_cmp++;
        if (seq_l.size() != 8) begin
            n_fail++;
            $display("FAIL en_ramp_steps: got %0d expected 8", seq_l.size());
        end else if (seq_l[0] !== 8'd16 || seq_l[7] !== 8'd128) begin
            n_fail++;
            $display("FAIL en_ramp_seq: got %0d..%0d expected 16..128",
                     seq_l[0], seq_l[7]);
        end
        n_cmp++;
        if (duty_right !== 8'd128) begin
            n_fail++;
            $display("FAIL en_ramp_r: got %0d expected 128", duty_right);
        end
    endtask

    task automatic test_reset_mid();
        pulse(8'd0, 8'd200);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (duty_left !== 8'd0 || duty_right !== 8'd0 ||
            pwm_left !== 1'b0 || pwm_right !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got %0d/%0d pwm %b%b expected 0",
                     duty_left, duty_right, pwm_left, pwm_right);
        end
        n_cmp++;
        if (timed_out !== 1'b1 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got to=%b act=%b expected 1 0",
                     timed_out, active);
        end
        #2;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (duty_left !== 8'd0 || timed_out !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got %0d to=%b expected 0 1",
                     duty_left, timed_out);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_mix_64();
        test_sat_high();
        test_cross();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
